// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter range checks for the FIFO family.
package fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned a_size);
    return a_size + 32'd1;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned a_size);
    return 32'd1 << a_size;
  endfunction

  // afull threshold must be reachable and non-trivial: 1..DEPTH
  function automatic bit af_level_ok(input int unsigned af, input int unsigned a_size);
    return (af >= 32'd1) && (af <= fifo_depth(a_size));
  endfunction

  // aempty threshold must leave full distinguishable: 0..DEPTH-1
  function automatic bit ae_level_ok(input int unsigned ae, input int unsigned a_size);
    return ae < fifo_depth(a_size);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x D_SIZE storage with one write port and a registered, read-enable gated read port.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned A_SIZE = 4,
  parameter int unsigned D_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [A_SIZE-1:0] waddr,
  input  logic [D_SIZE-1:0] wdata,
  input  logic              re,
  input  logic [A_SIZE-1:0] raddr,
  output logic [D_SIZE-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(A_SIZE);

  logic [D_SIZE-1:0] mem [DEPTH];

  // Array is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a same-address write in this cycle is not visible here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, status flag, fill count and sticky error logic around sync_fifo_ram.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned A_SIZE   = 4,
  parameter int unsigned D_SIZE   = 8,
  parameter int unsigned AF_LEVEL = (2 ** A_SIZE) - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [D_SIZE-1:0] wdata,
  input  logic              ren,
  output logic [D_SIZE-1:0] rdata,
  output logic              rvalid,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic [A_SIZE:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned PW = ptr_width(A_SIZE);
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

  if (!af_level_ok(AF_LEVEL, A_SIZE)) begin : g_af_range
    $error("sync_fifo: AF_LEVEL outside 1..DEPTH");
  end
  if (!ae_level_ok(AE_LEVEL, A_SIZE)) begin : g_ae_range
    $error("sync_fifo: AE_LEVEL outside 0..DEPTH-1");
  end

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_nxt, rptr_nxt, cnt_nxt;
  logic          ren_acc, wen_acc;
  logic          full_nxt, empty_nxt, afull_nxt, aempty_nxt;
  logic          ovf_nxt, unf_nxt;

  // Acceptance uses registered flags only; a read frees a slot for a write while full.
  always_comb begin
    ren_acc    = ren & ~empty;
    wen_acc    = wen & (~full | ren_acc);
    wptr_nxt   = wptr + PW'(wen_acc);
    rptr_nxt   = rptr + PW'(ren_acc);
    cnt_nxt    = wptr_nxt - rptr_nxt;
    empty_nxt  = (wptr_nxt == rptr_nxt);
    full_nxt   = (wptr_nxt[PW-1] != rptr_nxt[PW-1]) &&
                 (wptr_nxt[PW-2:0] == rptr_nxt[PW-2:0]);
    afull_nxt  = (cnt_nxt >= AF_L);
    aempty_nxt = (cnt_nxt <= AE_L);
    // A new error in the clearing cycle wins over the clear.
    ovf_nxt    = (overflow  & ~clr_err) | (wen & ~wen_acc);
    unf_nxt    = (underflow & ~clr_err) | (ren & empty);
  end

  // Flags are registered from next-state pointers so they track wptr/rptr exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      empty     <= 1'b1;
      aempty    <= 1'b1;
      full      <= 1'b0;
      afull     <= 1'b0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      count     <= cnt_nxt;
      empty     <= empty_nxt;
      aempty    <= aempty_nxt;
      full      <= full_nxt;
      afull     <= afull_nxt;
      rvalid    <= ren_acc;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  sync_fifo_ram #(
    .A_SIZE (A_SIZE),
    .D_SIZE (D_SIZE)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wen_acc),
    .waddr (wptr[A_SIZE-1:0]),
    .wdata (wdata),
    .re    (ren_acc),
    .raddr (rptr[A_SIZE-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned A     = 4;
  localparam int unsigned D     = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wen = 1'b0;
  logic         ren = 1'b0;
  logic         clr_err = 1'b0;
  logic [D-1:0] wdata = '0;
  logic [D-1:0] rdata;
  logic         rvalid, full, empty, afull, aempty, overflow, underflow;
  logic [A:0]   count;

  sync_fifo #(
    .A_SIZE   (A),
    .D_SIZE   (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .wdata     (wdata),
    .ren       (ren),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .full      (full),
    .empty     (empty),
    .afull     (afull),
    .aempty    (aempty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [D-1:0] q[$];
  logic [D-1:0] m_rdata = '0;
  bit           m_rvalid = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"},     32'(count),     32'(n));
    check({tag, ".empty"},     32'(empty),     32'(n == 0));
    check({tag, ".full"},      32'(full),      32'(n == DEPTH));
    check({tag, ".afull"},     32'(afull),     32'(n >= AF));
    check({tag, ".aempty"},    32'(aempty),    32'(n <= AE));
    check({tag, ".rvalid"},    32'(rvalid),    32'(m_rvalid));
    check({tag, ".rdata"},     32'(rdata),     32'(m_rdata));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  // One clock of stimulus; model applies the FIFO rules to its queue at the edge.
  task automatic step(input string tag, input bit w, input logic [D-1:0] wd,
                      input bit r, input bit c);
    bit was_full, was_empty, racc, wacc;
    wen = w; wdata = wd; ren = r; clr_err = c;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    racc = r && !was_empty;
    wacc = w && (!was_full || racc);
    m_rvalid = racc;
    if (racc) m_rdata = q.pop_front();
    if (wacc) q.push_back(wd);
    m_ovf = (m_ovf && !c) || (w && !wacc);
    m_unf = (m_unf && !c) || (r && was_empty);
    #1;
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int wprob;
    model_reset();
    rst_n = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) step("fill", 1'b1, D'(i), 1'b0, 1'b0);
    check("fill.full_done", 32'(full), 32'd1);

    step("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
    step("ovf_hold", 1'b0, '0, 1'b0, 1'b0);
    step("ovf_clr", 1'b0, '0, 1'b0, 1'b1);
    step("ovf_clr_race", 1'b1, 8'hAB, 1'b0, 1'b1);
    step("ovf_clr2", 1'b0, '0, 1'b0, 1'b1);

    step("full_rw", 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    check("drain.last", 32'(rdata), 32'h55);

    step("empty_rw", 1'b1, 8'h33, 1'b1, 1'b0);
    step("empty_rd", 1'b0, '0, 1'b1, 1'b0);
    step("unf_clr", 1'b0, '0, 1'b0, 1'b1);

    // Random traffic with drifting occupancy to exercise pointer wrap and both limits.
    wprob = 70;
    for (int i = 0; i < 300; i++) begin
      if ((i % 25) == 0) wprob = (wprob == 70) ? 30 : 70;
      step("rand", $urandom_range(0, 99) < wprob, D'($urandom),
           $urandom_range(0, 99) < (100 - wprob), $urandom_range(0, 15) == 0);
    end

    while (q.size() < 5) step("prefill", 1'b1, D'($urandom), 1'b0, 1'b0);
    step("pre_rst_rd", 1'b0, '0, 1'b1, 1'b0);
    check("pre_rst.rvalid", 32'(rvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_w", 1'b1, 8'h7E, 1'b0, 1'b0);
    step("post_rst_r", 1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
